// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-lane data RAM: one request at a time, size/range/alignment
// checks, lane steering, load extension. MAU_ALIGN_FAULT_EN: fault on misaligned half/word.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  ram_size,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

    state_t      state, state_next;
    logic        wr_q, sgn_q;
    logic        accept;
    logic        size_bad, range_bad, fault;
    logic [31:0] addr_eff;
    logic [31:0] wdata_steer;
    logic [31:0] load_ext;

    assign accept    = req_valid && req_ready;
    assign size_bad  = (req_size == 2'b11);
    assign range_bad = |req_addr[31:ADDR_WIDTH];

`ifdef MAU_ALIGN_FAULT_EN
    logic misalign;
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign fault    = size_bad | range_bad | misalign;
    assign addr_eff = req_addr;
`else
    assign fault = size_bad | range_bad;
    // Without alignment faults the low address bits are dropped so the RAM sees a natural access.
    always_comb begin
        addr_eff = req_addr;
        if (req_size == 2'b01) addr_eff[0] = 1'b0;
        else if (req_size == 2'b10) addr_eff[1:0] = 2'b00;
    end
`endif

    always_comb begin
        case (req_size)
            2'b00:   wdata_steer = {4{req_wdata[7:0]}};
            2'b01:   wdata_steer = {2{req_wdata[15:0]}};
            default: wdata_steer = req_wdata;
        endcase
    end

    always_comb begin
        case (ram_size)
            2'b00:   load_ext = sgn_q ? {{24{ram_rdata[7]}}, ram_rdata[7:0]}
                                      : {24'b0, ram_rdata[7:0]};
            2'b01:   load_ext = sgn_q ? {{16{ram_rdata[15]}}, ram_rdata[15:0]}
                                      : {16'b0, ram_rdata[15:0]};
            default: load_ext = ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fault ? RESP : ACCESS;
            ACCESS:  state_next = wr_q ? RESP : DATA;
            DATA:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        ram_we    = (state == ACCESS) && wr_q && !rst;
    end

    // A faulting request leaves the RAM port untouched, so a reserved size never reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            sgn_q     <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_fault <= 1'b0;
            ram_size  <= 2'b00;
            ram_addr  <= 32'b0;
            ram_wdata <= 32'b0;
        end else begin
            if (accept) begin
                wr_q      <= req_write;
                sgn_q     <= req_signed;
                rsp_rdata <= 32'b0;
                rsp_fault <= fault;
                if (!fault) begin
                    ram_size  <= req_size;
                    ram_addr  <= addr_eff;
                    ram_wdata <= wdata_steer;
                end
            end
            if (state == DATA) rsp_rdata <= load_ext;
        end
    end

endmodule
